// File: rtl/anvil_mem_arbiter_pkg.sv
// Shared types and constants for the anvil instruction/data memory arbiter.
// Holds FSM state encodings, tie-break policy codes and the captured-request layout.
package anvil_mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GNT_I = 2'd1,
    ST_GNT_D = 2'd2
  } state_e;

  typedef enum logic {
    SIDE_INSTR = 1'b0,
    SIDE_DATA  = 1'b1
  } side_e;

  localparam int unsigned POLICY_RR    = 0;
  localparam int unsigned POLICY_DATA  = 1;
  localparam int unsigned POLICY_INSTR = 2;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } req_t;

endpackage

// File: rtl/anvil_mem_arbiter_if.sv
// Generic valid/ready memory bus used on both core buses and the shared memory port.
// The requester drives valid/addr/wdata/wstrb; the responder drives ready/rdata.
interface anvil_mem_arbiter_if;
  logic        valid;
  logic        ready;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic [31:0] rdata;

  modport master (
    output valid,
    output addr,
    output wdata,
    output wstrb,
    input  ready,
    input  rdata
  );

  modport slave (
    input  valid,
    input  addr,
    input  wdata,
    input  wstrb,
    output ready,
    output rdata
  );
endinterface

// File: rtl/anvil_mem_arbiter_arb_pick2.sv
// Combinational 2-way picker: a lone request always wins; ties follow POLICY
// (round-robin against rr_last, data first, or instruction first).
module anvil_arb_pick2
  import anvil_mem_arbiter_pkg::*;
#(
  parameter int unsigned POLICY = POLICY_RR
) (
  input  logic  i_valid_i,
  input  logic  d_valid_i,
  input  side_e rr_last_i,
  output logic  grant_i_o,
  output logic  grant_d_o
);

  logic prefer_d;
  logic unused_rr;

  generate
    if (POLICY == POLICY_DATA) begin : g_data_first
      assign prefer_d = 1'b1;
    end else if (POLICY == POLICY_INSTR) begin : g_instr_first
      assign prefer_d = 1'b0;
    end else begin : g_round_robin
      // Favour whichever side did not win the previous grant.
      assign prefer_d = (rr_last_i == SIDE_INSTR);
    end
  endgenerate

  assign unused_rr = (rr_last_i == SIDE_DATA);

  always_comb begin
    grant_d_o = d_valid_i && (!i_valid_i || prefer_d);
    grant_i_o = i_valid_i && (!d_valid_i || !prefer_d);
  end

endmodule

// File: rtl/anvil_mem_arbiter.sv
// Shares one memory port between the anvil instruction and data buses: picks a winner,
// registers its request onto the memory port, routes the response back, aborts stalls.
module anvil_mem_arbiter
  import anvil_mem_arbiter_pkg::*;
#(
  parameter int unsigned POLICY         = POLICY_RR,
  parameter int unsigned TIMEOUT_CYCLES = 0,
  parameter logic [31:0] ERR_DATA       = 32'hDEAD_BEEF
) (
  input  logic                 clk,
  input  logic                 resetn,
  anvil_mem_arbiter_if.slave   i_bus,
  anvil_mem_arbiter_if.slave   d_bus,
  anvil_mem_arbiter_if.master  m_bus,
  output logic                 err_timeout
);

  localparam bit              WD_EN    = (TIMEOUT_CYCLES > 0);
  localparam int unsigned     WD_W     = WD_EN ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT_CYCLES);
  localparam logic [WD_W-1:0] WD_MAX   = {WD_W{1'b1}};

  state_e          state_q, state_d;
  side_e           rr_last_q, rr_last_d;
  logic            m_valid_q, m_valid_d;
  req_t            req_q, req_d;
  logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;
  logic            err_q, err_d;

  logic            grant_i;
  logic            grant_d;
  logic            in_grant;
  logic            timeout_hit;
  logic            resp_fire;
  logic [31:0]     resp_data;
  logic            unused_ibus;

  anvil_arb_pick2 #(
    .POLICY (POLICY)
  ) u_pick (
    .i_valid_i (i_bus.valid),
    .d_valid_i (d_bus.valid),
    .rr_last_i (rr_last_q),
    .grant_i_o (grant_i),
    .grant_d_o (grant_d)
  );

  // Instruction fetches never write; their wdata/wstrb are dropped on capture.
  assign unused_ibus = ^{i_bus.wdata, i_bus.wstrb};

  assign in_grant = (state_q == ST_GNT_I) || (state_q == ST_GNT_D);

  generate
    if (WD_EN) begin : g_watchdog
      // m_ready in the same cycle wins over the abort.
      assign timeout_hit = in_grant && !m_bus.ready && (wd_cnt_q == WD_LIMIT);
    end else begin : g_no_watchdog
      assign timeout_hit = 1'b0;
    end
  endgenerate

  always_comb begin
    state_d   = state_q;
    rr_last_d = rr_last_q;
    m_valid_d = m_valid_q;
    req_d     = req_q;
    wd_cnt_d  = wd_cnt_q;
    err_d     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (grant_d) begin
          req_d     = '{addr: d_bus.addr, wdata: d_bus.wdata, wstrb: d_bus.wstrb};
          m_valid_d = 1'b1;
          state_d   = ST_GNT_D;
          rr_last_d = SIDE_DATA;
          wd_cnt_d  = '0;
        end else if (grant_i) begin
          req_d     = '{addr: i_bus.addr, wdata: 32'd0, wstrb: 4'd0};
          m_valid_d = 1'b1;
          state_d   = ST_GNT_I;
          rr_last_d = SIDE_INSTR;
          wd_cnt_d  = '0;
        end
      end
      ST_GNT_I, ST_GNT_D: begin
        if (m_bus.ready) begin
          m_valid_d = 1'b0;
          state_d   = ST_IDLE;
        end else if (timeout_hit) begin
          m_valid_d = 1'b0;
          state_d   = ST_IDLE;
          err_d     = 1'b1;
        end else if (WD_EN && (wd_cnt_q != WD_MAX)) begin
          wd_cnt_d = wd_cnt_q + WD_W'(1);
        end
      end
      default: begin
        m_valid_d = 1'b0;
        state_d   = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q   <= ST_IDLE;
      rr_last_q <= SIDE_INSTR;
      m_valid_q <= 1'b0;
      req_q     <= '0;
      wd_cnt_q  <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      rr_last_q <= rr_last_d;
      m_valid_q <= m_valid_d;
      req_q     <= req_d;
      wd_cnt_q  <= wd_cnt_d;
      err_q     <= err_d;
    end
  end

  assign m_bus.valid = m_valid_q;
  assign m_bus.addr  = req_q.addr;
  assign m_bus.wdata = req_q.wdata;
  assign m_bus.wstrb = req_q.wstrb;
  assign err_timeout = err_q;

  // Responses are combinational; a requester that dropped valid gets nothing back,
  // and no ready escapes while reset is being applied.
  assign resp_fire = resetn && (m_bus.ready || timeout_hit);
  assign resp_data = timeout_hit ? ERR_DATA : m_bus.rdata;

  assign i_bus.ready = (state_q == ST_GNT_I) && i_bus.valid && resp_fire;
  assign d_bus.ready = (state_q == ST_GNT_D) && d_bus.valid && resp_fire;
  assign i_bus.rdata = resp_data;
  assign d_bus.rdata = resp_data;

endmodule
